// File: rtl/adder_tree_signed_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_signed_pipelined
// Description : Pipelined signed adder tree, one register level per tree
//               level, followed by a frame accumulator closed by in_last.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_signed_pipelined #(
    parameter int WIDTH     = 4,
    parameter int N_INPUTS  = 16,
    parameter int ACC_EXTRA = 4,
    parameter int LEVELS     = $clog2(N_INPUTS),
    parameter int TREE_WIDTH = WIDTH + LEVELS,
    parameter int OUT_WIDTH  = TREE_WIDTH + ACC_EXTRA
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_INPUTS*WIDTH-1:0]   in,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic [OUT_WIDTH-1:0]        out,
    output logic                        out_valid
);

    logic [LEVELS-1:0]     r_vld;
    logic [LEVELS-1:0]     r_lst;
    logic [TREE_WIDTH-1:0] w_tree;
    logic [OUT_WIDTH-1:0]  w_s;
    logic [OUT_WIDTH-1:0]  w_acc_next;
    logic [OUT_WIDTH-1:0]  r_acc;
    logic [OUT_WIDTH-1:0]  r_out;
    logic                  r_out_valid;
    logic                  r_open;

    genvar k;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_level
            localparam int LW = WIDTH + k;
            localparam int LN = N_INPUTS >> k;

            logic [LN*LW-1:0]       r_bus;
            logic [2*LN*(LW-1)-1:0] w_prev;

            if (k == 1) begin : g_leaf
                assign w_prev = in;
            end else begin : g_inner
                assign w_prev = g_level[k-1].r_bus;
            end

            // Each pair is sign-extended by one bit, so the sum is exact.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bus <= '0;
                end else begin
                    for (int j = 0; j < LN; j++) begin
                        r_bus[j*LW +: LW] <= LW'($signed(w_prev[(2*j)*(LW-1) +: LW-1]))
                                           + LW'($signed(w_prev[(2*j+1)*(LW-1) +: LW-1]));
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld <= (r_vld << 1) | LEVELS'(in_valid);
            r_lst <= (r_lst << 1) | LEVELS'(in_valid & in_last);
        end
    end

    assign w_tree     = g_level[LEVELS].r_bus;
    assign w_s        = OUT_WIDTH'($signed(w_tree));
    assign w_acc_next = r_open ? (r_acc + w_s) : w_s;

    // A closed frame restarts from the incoming beat, never from the old acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_open      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_vld[LEVELS-1]) begin
                r_acc <= w_acc_next;
                if (r_lst[LEVELS-1]) begin
                    r_out       <= w_acc_next;
                    r_out_valid <= 1'b1;
                    r_open      <= 1'b0;
                end else begin
                    r_open      <= 1'b1;
                end
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_signed_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree_signed_pipelined
// Description : Directed self-checking bench, default build plus ACC_EXTRA=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_tree_signed_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in;
    logic        in_valid;
    logic        in_last;
    logic [11:0] out;
    logic        out_valid;
    logic [7:0]  out0;
    logic        out_valid0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    adder_tree_signed_pipelined #(.WIDTH(4), .N_INPUTS(16), .ACC_EXTRA(4)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_last(in_last),
        .out(out), .out_valid(out_valid)
    );

    adder_tree_signed_pipelined #(.WIDTH(4), .N_INPUTS(16), .ACC_EXTRA(0)) dut0 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_last(in_last),
        .out(out0), .out_valid(out_valid0)
    );

    function automatic logic [63:0] all4(input logic [3:0] x);
        return {16{x}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a beat schedule, then idles; records every pulse seen on dut.
    task automatic run(input int n, input logic [63:0] d[8], input logic vv[8],
                       input logic ll[8], input int extra,
                       output int pulses, output logic [11:0] vals[8],
                       output logic [7:0] vals0[8], output int ats[8]);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = '0; vals0[i] = '0; ats[i] = -1;
        end
        for (int i = 0; i < n + extra; i++) begin
            if (i < n) begin
                in = d[i]; in_valid = vv[i]; in_last = ll[i];
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (pulses < 8) begin
                    vals[pulses] = out; vals0[pulses] = out0; ats[pulses] = i;
                end
                pulses++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in = '0; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) tick();
        n_total++; if (out !== 12'h000) $display("FAIL reset_out got=%h exp=000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out0 !== 8'h00) $display("FAIL reset_out0 got=%h exp=00", out0); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_ramp;
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'(i);
        in = v; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL ramp_early edge+%0d got=%b exp=0", i, out_valid); else n_pass++;
        end
        tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL ramp_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out !== 12'hFF8) $display("FAIL ramp_out got=%h exp=ff8", out); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL ramp_pulse_width got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out !== 12'hFF8) $display("FAIL ramp_hold got=%h exp=ff8", out); else n_pass++;
    endtask

    task automatic test_extremes;
        logic [63:0] d[8]; logic vv[8]; logic ll[8];
        int p; logic [11:0] vals[8]; logic [7:0] v0[8]; int ats[8];
        for (int i = 0; i < 8; i++) begin d[i] = '0; vv[i] = 1'b0; ll[i] = 1'b0; end
        d[0] = all4(4'h8); vv[0] = 1'b1; ll[0] = 1'b1;
        d[1] = all4(4'h0); vv[1] = 1'b1; ll[1] = 1'b1;
        run(2, d, vv, ll, 6, p, vals, v0, ats);
        n_total++; if (p !== 2) $display("FAIL extremes_pulses got=%0d exp=2", p); else n_pass++;
        n_total++; if (vals[0] !== 12'hF80) $display("FAIL extremes_min got=%h exp=f80", vals[0]); else n_pass++;
        n_total++; if (vals[1] !== 12'h000) $display("FAIL extremes_zero got=%h exp=000", vals[1]); else n_pass++;
        n_total++; if (ats[0] !== 4) $display("FAIL extremes_latency got=%0d exp=4", ats[0]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] d[8]; logic vv[8]; logic ll[8];
        int p; logic [11:0] vals[8]; logic [7:0] v0[8]; int ats[8];
        for (int i = 0; i < 8; i++) begin d[i] = '0; vv[i] = 1'b0; ll[i] = 1'b0; end
        d[0] = all4(4'h1); d[1] = all4(4'hF); d[2] = all4(4'h7);
        for (int i = 0; i < 3; i++) begin vv[i] = 1'b1; ll[i] = 1'b1; end
        run(3, d, vv, ll, 6, p, vals, v0, ats);
        n_total++; if (p !== 3) $display("FAIL b2b_pulses got=%0d exp=3", p); else n_pass++;
        n_total++; if (vals[0] !== 12'h010) $display("FAIL b2b_v0 got=%h exp=010", vals[0]); else n_pass++;
        n_total++; if (vals[1] !== 12'hFF0) $display("FAIL b2b_v1 got=%h exp=ff0", vals[1]); else n_pass++;
        n_total++; if (vals[2] !== 12'h070) $display("FAIL b2b_v2 got=%h exp=070", vals[2]); else n_pass++;
        n_total++;
        if (ats[0] !== 4 || ats[1] !== 5 || ats[2] !== 6)
            $display("FAIL b2b_timing got=%0d,%0d,%0d exp=4,5,6", ats[0], ats[1], ats[2]);
        else n_pass++;
    endtask

    task automatic test_frame_bubbles;
        logic [63:0] d[8]; logic vv[8]; logic ll[8];
        int p; logic [11:0] vals[8]; logic [7:0] v0[8]; int ats[8];
        for (int i = 0; i < 8; i++) begin d[i] = all4(4'h7); vv[i] = 1'b0; ll[i] = 1'b0; end
        vv[0] = 1'b1; vv[1] = 1'b1; vv[4] = 1'b1; vv[5] = 1'b1; ll[5] = 1'b1;
        ll[2] = 1'b1; // last on a bubble must be ignored
        run(6, d, vv, ll, 7, p, vals, v0, ats);
        n_total++; if (p !== 1) $display("FAIL frame_pulses got=%0d exp=1", p); else n_pass++;
        n_total++; if (vals[0] !== 12'h1C0) $display("FAIL frame_sum got=%h exp=1c0", vals[0]); else n_pass++;
        n_total++; if (ats[0] !== 9) $display("FAIL frame_timing got=%0d exp=9", ats[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] d[8]; logic vv[8]; logic ll[8];
        int p; logic [11:0] vals[8]; logic [7:0] v0[8]; int ats[8];
        in = all4(4'h1); in_valid = 1'b1; in_last = 1'b0;
        tick(); tick();
        rst = 1'b1; in_last = 1'b1;
        tick();
        n_total++; if (out !== 12'h000) $display("FAIL midrst_out got=%h exp=000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out0 !== 8'h00) $display("FAIL midrst_out0 got=%h exp=00", out0); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin d[i] = '0; vv[i] = 1'b0; ll[i] = 1'b0; end
        d[0] = all4(4'h1); vv[0] = 1'b1; ll[0] = 1'b1;
        run(1, d, vv, ll, 7, p, vals, v0, ats);
        n_total++; if (p !== 1) $display("FAIL midrst_pulses got=%0d exp=1", p); else n_pass++;
        n_total++; if (vals[0] !== 12'h010) $display("FAIL midrst_sum got=%h exp=010", vals[0]); else n_pass++;
    endtask

    task automatic test_acc_wrap;
        logic [63:0] d[8]; logic vv[8]; logic ll[8];
        int p; logic [11:0] vals[8]; logic [7:0] v0[8]; int ats[8];
        for (int i = 0; i < 8; i++) begin d[i] = '0; vv[i] = 1'b0; ll[i] = 1'b0; end
        d[0] = all4(4'h8); d[1] = all4(4'h8); vv[0] = 1'b1; vv[1] = 1'b1; ll[1] = 1'b1;
        d[2] = all4(4'h8); d[3] = 64'h1; vv[2] = 1'b1; vv[3] = 1'b1; ll[3] = 1'b1;
        run(4, d, vv, ll, 6, p, vals, v0, ats);
        n_total++; if (p !== 2) $display("FAIL wrap_pulses got=%0d exp=2", p); else n_pass++;
        n_total++; if (v0[0] !== 8'h00) $display("FAIL wrap_out0 got=%h exp=00", v0[0]); else n_pass++;
        n_total++; if (vals[0] !== 12'hF00) $display("FAIL wrap_wide got=%h exp=f00", vals[0]); else n_pass++;
        n_total++; if (v0[1] !== 8'h81) $display("FAIL wrap_fresh got=%h exp=81", v0[1]); else n_pass++;
        n_total++; if (vals[1] !== 12'hF81) $display("FAIL wrap_fresh_wide got=%h exp=f81", vals[1]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_ramp();
        test_extremes();
        test_back_to_back();
        test_frame_bubbles();
        test_reset_mid_frame();
        test_acc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
